// File: rtl/hazard_ctrl_p_if.sv
// Signal bundle between the 5-stage pipeline (master) and the hazard controller (slave).
// Level signals, no valid/ready: the controller's outputs are combinational and take effect at the next rising edge.
interface hazard_ctrl_p_if #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
);
    logic [1:0]       pc_src;
    logic             halt_req;
    logic             mem_busy;
    logic [RA_W-1:0]  id_rs;
    logic [RA_W-1:0]  id_rt;
    logic             id_rs_vld;
    logic             id_rt_vld;
    logic [RA_W-1:0]  ex_rs;
    logic [RA_W-1:0]  ex_rt;
    logic [RA_W-1:0]  ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [RA_W-1:0]  mem_rd;
    logic             mem_regwrite;
    logic [RA_W-1:0]  wb_rd;
    logic             wb_regwrite;

    logic             pc_hold;
    logic             fd_hold;
    logic             fd_nop;
    logic             de_nop;
    logic             em_nop;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state_dbg;

    modport master (
        output pc_src, halt_req, mem_busy,
        output id_rs, id_rt, id_rs_vld, id_rt_vld,
        output ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  pc_hold, fd_hold, fd_nop, de_nop, em_nop, freeze,
        input  fwd_a, fwd_b, halted, stall_cycles, state_dbg
    );

    modport slave (
        input  pc_src, halt_req, mem_busy,
        input  id_rs, id_rt, id_rs_vld, id_rt_vld,
        input  ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output pc_hold, fd_hold, fd_nop, de_nop, em_nop, freeze,
        output fwd_a, fwd_b, halted, stall_cycles, state_dbg
    );
endinterface

// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard controller: PC/IF-ID holds, NOP injection, freeze, halt drain, EX forwarding, stall counter.
// Build macro HAZARD_FWD_EN: load-use-only stalls of LOAD_STALL bubbles plus EX forwarding selects.
module hazard_ctrl_p #(
    parameter int RA_W       = 3,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_p_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] BUB_INIT   = 2'(LOAD_STALL - 1);
    localparam logic [1:0] DRAIN_INIT = 2'd3;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       bub_q;
    logic [1:0]       bub_d;
    logic [1:0]       drain_q;
    logic [1:0]       drain_d;
    logic [CNT_W-1:0] cnt_q;

    logic frz;
    logic haz;
    logic stall;
    logic pc_hold;
    logic fd_hold;
    logic fd_nop;
    logic de_nop;
    logic em_nop;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic src_hit(input logic [RA_W-1:0] src, input logic vld,
                                     input logic [RA_W-1:0] dst, input logic wr);
        return vld && wr && (src != '0) && (src == dst);
    endfunction

    assign frz = bus.mem_busy;

`ifdef HAZARD_FWD_EN
    assign haz = bus.ex_memread &&
                 (src_hit(bus.id_rs, bus.id_rs_vld, bus.ex_rd, bus.ex_regwrite) ||
                  src_hit(bus.id_rt, bus.id_rt_vld, bus.ex_rd, bus.ex_regwrite));

    assign bus.fwd_a = (bus.mem_regwrite && (bus.ex_rs != '0) && (bus.mem_rd == bus.ex_rs)) ? 2'b01 :
                       (bus.wb_regwrite  && (bus.ex_rs != '0) && (bus.wb_rd  == bus.ex_rs)) ? 2'b10 :
                                                                                               2'b00;
    assign bus.fwd_b = (bus.mem_regwrite && (bus.ex_rt != '0) && (bus.mem_rd == bus.ex_rt)) ? 2'b01 :
                       (bus.wb_regwrite  && (bus.ex_rt != '0) && (bus.wb_rd  == bus.ex_rt)) ? 2'b10 :
                                                                                               2'b00;
`else
    // Without forwarding any in-flight producer in EX or MEM must be waited out.
    assign haz = src_hit(bus.id_rs, bus.id_rs_vld, bus.ex_rd,  bus.ex_regwrite)  ||
                 src_hit(bus.id_rt, bus.id_rt_vld, bus.ex_rd,  bus.ex_regwrite)  ||
                 src_hit(bus.id_rs, bus.id_rs_vld, bus.mem_rd, bus.mem_regwrite) ||
                 src_hit(bus.id_rt, bus.id_rt_vld, bus.mem_rd, bus.mem_regwrite);

    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;

    logic fwd_unused;
    assign fwd_unused = ^{bus.ex_rs, bus.ex_rt, bus.wb_rd, bus.wb_regwrite, bus.ex_memread};
`endif

    assign stall = !frz && (((state_q == RUN) && haz) || (state_q == LSTALL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            bub_q   <= 2'd0;
            drain_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            drain_q <= drain_d;
            if ((frz || stall) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        drain_d = drain_q;
        if (!frz) begin
            case (state_q)
                RUN: begin
                    if (haz) begin
                        if (FWD && (LOAD_STALL > 1)) begin
                            state_d = LSTALL;
                            bub_d   = BUB_INIT;
                        end
                    end else if (!bus.pc_src[1] && bus.halt_req) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
                LSTALL: begin
                    // A fresh load-use on the final bubble restarts the count instead of returning to RUN.
                    if (bub_q <= 2'd1) begin
                        if (haz) begin
                            bub_d = BUB_INIT;
                        end else begin
                            state_d = RUN;
                            bub_d   = 2'd0;
                        end
                    end else begin
                        bub_d = bub_q - 2'd1;
                    end
                end
                DRAIN: begin
                    drain_d = (drain_q != 2'd0) ? drain_q - 2'd1 : 2'd0;
                    if (drain_q <= 2'd1) begin
                        state_d = HALTED;
                    end
                end
                default: begin
                    state_d = HALTED;
                end
            endcase
        end
    end

    always_comb begin
        pc_hold = 1'b0;
        fd_hold = 1'b0;
        fd_nop  = 1'b0;
        de_nop  = 1'b0;
        em_nop  = 1'b0;
        if (frz) begin
            pc_hold = 1'b1;
            fd_hold = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (haz) begin
                        pc_hold = 1'b1;
                        fd_hold = 1'b1;
                        de_nop  = 1'b1;
                    end else if (bus.pc_src[1]) begin
                        fd_nop  = 1'b1;
                    end else if (bus.halt_req) begin
                        pc_hold = 1'b1;
                        fd_hold = 1'b1;
                        fd_nop  = 1'b1;
                    end
                end
                LSTALL: begin
                    pc_hold = 1'b1;
                    fd_hold = 1'b1;
                    de_nop  = 1'b1;
                end
                DRAIN: begin
                    pc_hold = 1'b1;
                    fd_hold = 1'b1;
                end
                default: begin
                    pc_hold = 1'b1;
                    fd_hold = 1'b1;
                    em_nop  = 1'b1;
                end
            endcase
        end
    end

    assign bus.pc_hold      = pc_hold;
    assign bus.fd_hold      = fd_hold;
    assign bus.fd_nop       = fd_nop;
    assign bus.de_nop       = de_nop;
    assign bus.em_nop       = em_nop;
    assign bus.freeze       = frz;
    assign bus.halted       = (state_q == HALTED);
    assign bus.stall_cycles = cnt_q;
    assign bus.state_dbg    = state_q;
endmodule
